// File: rtl/frogger_color_pipe.sv
// Two-stage VGA colour pipe: sprite transparency, palette lookup and frame-stepped fade.
// Optional SCANLINE_EN halves the faded colour on lines whose DrawY0 is 1.
module frogger_color_pipe #(
  parameter int NUM_COLORS  = 18,
  parameter int IDX_W       = 5,
  parameter int FADE_FRAMES = 4,
  parameter int TRANSP_IDX  = 0
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [0:NUM_COLORS-1][0:2][7:0]   palette,
  input  logic [IDX_W-1:0]                  sprite_idx,
  input  logic [IDX_W-1:0]                  bg_idx,
  input  logic                              blank_n_in,
  input  logic                              hs_in,
  input  logic                              vs_in,
  input  logic                              DrawY0,
  input  logic                              frame_start,
  input  logic                              fade_out_req,
  input  logic                              fade_in_req,
  output logic [7:0]                        VGA_R,
  output logic [7:0]                        VGA_G,
  output logic [7:0]                        VGA_B,
  output logic                              VGA_BLANK_N,
  output logic                              VGA_HS,
  output logic                              VGA_VS,
  output logic [3:0]                        fade_level,
  output logic                              fade_busy,
  output logic                              fade_done
);

  typedef enum logic [1:0] {BRIGHT, FADE_OUT, DARK, FADE_IN} fade_state_t;

  fade_state_t      r_state;
  logic [3:0]       r_level;
  logic [7:0]       r_cnt;
  logic             r_done;

  logic [IDX_W-1:0] w_sel;
  logic             w_black;
  logic [IDX_W-1:0] w_lut_idx;
  logic             w_step;
  logic [3:0]       w_lvl_dn;
  logic [3:0]       w_lvl_up;

  logic [IDX_W-1:0] r_sel;
  logic             r_black;
  logic             r_blank_n;
  logic             r_hs;
  logic             r_vs;
  logic             r_y0;
  logic             r_blank_n_q;
  logic             r_hs_q;
  logic             r_vs_q;

  assign w_sel     = (sprite_idx != IDX_W'(TRANSP_IDX)) ? sprite_idx : bg_idx;
  assign w_black   = (32'(w_sel) >= NUM_COLORS);
  // Out-of-range indices never reach the table; they are zeroed by r_black.
  assign w_lut_idx = r_black ? '0 : r_sel;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sel       <= '0;
      r_black     <= 1'b0;
      r_blank_n   <= 1'b0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_y0        <= 1'b0;
      r_blank_n_q <= 1'b0;
      r_hs_q      <= 1'b0;
      r_vs_q      <= 1'b0;
    end else begin
      r_sel       <= w_sel;
      r_black     <= w_black;
      r_blank_n   <= blank_n_in;
      r_hs        <= hs_in;
      r_vs        <= vs_in;
      r_y0        <= DrawY0;
      r_blank_n_q <= r_blank_n;
      r_hs_q      <= r_hs;
      r_vs_q      <= r_vs;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [10:0] w_prod;
    logic [7:0]  w_chan;
    logic [7:0]  r_chan;

    assign w_prod = 11'(palette[w_lut_idx][gi]) * 11'(r_level);
`ifdef SCANLINE_EN
    assign w_chan = r_black ? 8'd0 : (r_y0 ? {1'b0, w_prod[10:4]} : w_prod[10:3]);
`else
    assign w_chan = r_black ? 8'd0 : w_prod[10:3];
`endif

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_chan <= 8'd0;
      else       r_chan <= r_blank_n ? w_chan : 8'd0;
    end
  end

`ifndef SCANLINE_EN
  logic w_unused_y0;
  assign w_unused_y0 = r_y0;
`endif

  assign w_step   = (r_cnt == 8'(FADE_FRAMES - 1));
  assign w_lvl_dn = (r_level == 4'd0) ? 4'd0 : r_level - 4'd1;
  assign w_lvl_up = (r_level >= 4'd8) ? 4'd8 : r_level + 4'd1;

  // Requests take priority over a coincident frame_start; fade_out_req beats fade_in_req.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= BRIGHT;
      r_level <= 4'd8;
      r_cnt   <= 8'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        BRIGHT: if (fade_out_req) begin
          r_state <= FADE_OUT;
          r_cnt   <= 8'd0;
        end
        DARK: if (!fade_out_req && fade_in_req) begin
          r_state <= FADE_IN;
          r_cnt   <= 8'd0;
        end
        FADE_OUT: begin
          if (!fade_out_req && fade_in_req) begin
            r_state <= FADE_IN;
            r_cnt   <= 8'd0;
          end else if (frame_start) begin
            if (w_step) begin
              r_cnt   <= 8'd0;
              r_level <= w_lvl_dn;
              if (w_lvl_dn == 4'd0) begin
                r_state <= DARK;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        FADE_IN: begin
          if (fade_out_req) begin
            r_state <= FADE_OUT;
            r_cnt   <= 8'd0;
          end else if (frame_start) begin
            if (w_step) begin
              r_cnt   <= 8'd0;
              r_level <= w_lvl_up;
              if (w_lvl_up == 4'd8) begin
                r_state <= BRIGHT;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= BRIGHT;
      endcase
    end
  end

  assign VGA_R       = g_chan[0].r_chan;
  assign VGA_G       = g_chan[1].r_chan;
  assign VGA_B       = g_chan[2].r_chan;
  assign VGA_BLANK_N = r_blank_n_q;
  assign VGA_HS      = r_hs_q;
  assign VGA_VS      = r_vs_q;
  assign fade_level  = r_level;
  assign fade_busy   = (r_state == FADE_OUT) || (r_state == FADE_IN);
  assign fade_done   = r_done;

endmodule

// File: doc/frogger_color_pipe.md
Name: frogger_color_pipe

Overview:
- Pixel-output stage directly downstream of the 18-entry RGB palette table.
- Takes per-pixel palette indices from the sprite layer and the background layer, plus VGA timing.
- Resolves sprite transparency, looks the winning index up in the palette, applies a frame-stepped fade (used for death and level transitions), and drives registered VGA_R/G/B aligned with delayed blank/sync.

Parameters:
- NUM_COLORS, 18, number of valid palette entries; indices >= NUM_COLORS map to black.
- IDX_W, 5, palette index width.
- FADE_FRAMES, 4, frame_start pulses per fade step (1..255).
- TRANSP_IDX, 0, sprite index treated as transparent.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- palette  in  [0:17][0:2]x8  RGB table, driven by the palette block.
- sprite_idx  in  IDX_W  sprite-layer palette index for the current pixel.
- bg_idx  in  IDX_W  background-layer palette index for the current pixel.
- blank_n_in  in  1  active-low blank, aligned with the indices.
- hs_in  in  1  horizontal sync, aligned with the indices.
- vs_in  in  1  vertical sync, aligned with the indices.
- DrawY0  in  1  LSB of the current line number, aligned with the indices.
- frame_start  in  1  one-cycle pulse once per frame.
- fade_out_req  in  1  pulse: begin fade to black.
- fade_in_req  in  1  pulse: begin fade to full brightness.
- VGA_R  out  8  red.
- VGA_G  out  8  green.
- VGA_B  out  8  blue.
- VGA_BLANK_N  out  1  delayed blank_n_in.
- VGA_HS  out  1  delayed hs_in.
- VGA_VS  out  1  delayed vs_in.
- fade_level  out  4  current brightness, 0..8.
- fade_busy  out  1  high in FADE_OUT or FADE_IN.
- fade_done  out  1  one-cycle pulse when DARK or BRIGHT is reached.

Behaviour:
- Reset (asynchronous): all pipeline registers 0 (so VGA_R/G/B=0, VGA_BLANK_N=0, VGA_HS=0, VGA_VS=0); state BRIGHT; fade_level=8; frame counter 0; fade_busy=0; fade_done=0.
- Stage 1 (cycle N+1):
  - sel = (sprite_idx != TRANSP_IDX) ? sprite_idx : bg_idx.
  - If sel >= NUM_COLORS, force the black flag.
  - Register sel, the black flag, blank_n, hs, vs and DrawY0.
- Stage 2 (cycle N+2):
  - rgb = black flag ? 0 : palette[sel].
  - Each channel out = (c * fade_level) >> 3, 11-bit intermediate, truncated to 8 bits.
  - If the registered blank_n is 0, output 0 on all channels.
  - Sync and blank outputs are the stage-1 values registered once more.
- Total latency: 2 cycles, fixed, no stalls.
- fade_level is sampled at stage 2; it changes only on the cycle after a frame_start, so it is constant within a frame.
- Fade FSM:
  - BRIGHT (level 8):
    - fade_out_req -> FADE_OUT.
    - fade_in_req ignored.
  - FADE_OUT:
    - Each frame_start increments the frame counter; when it reaches FADE_FRAMES-1, clear the counter and decrement the level.
    - When the level becomes 0 -> DARK and pulse fade_done.
  - DARK (level 0):
    - fade_in_req -> FADE_IN.
    - fade_out_req ignored.
  - FADE_IN:
    - Same stepping, incrementing the level.
    - When the level reaches 8 -> BRIGHT and pulse fade_done.
  - A request in the opposite direction during FADE_OUT/FADE_IN reverses direction from the current level and clears the frame counter; a same-direction request is ignored.
  - fade_out_req and fade_in_req in the same cycle: fade_out_req wins.
  - frame_start coincident with a request: the state transition takes effect and the counter clears; no step occurs that cycle.
- Level saturates at 0 and 8; it never wraps.
- Reset mid-fade returns immediately to BRIGHT with level 8.

Optional Feature:
- Macro: SCANLINE_EN.
- Defined:
  - At stage 2, pixels whose registered DrawY0 is 1 have each channel additionally shifted right by 1, applied after the fade scaling.
  - Blank still forces 0.
- Undefined: DrawY0 is ignored (port present, unused); output matches the fade-scaled colour exactly.

Test Plan:
- Palette loaded with table values; sprite_idx=10, blank_n_in=1 at cycle N -> at N+2, RGB=(250,0,0) and VGA_BLANK_N=1; hs/vs pulse delayed exactly 2 cycles.
- sprite_idx=0, bg_idx=3 -> RGB=(30,150,0).
- sprite_idx=14, bg_idx=3 -> RGB=(250,250,250).
- sprite_idx=0, bg_idx=20 -> RGB=(0,0,0).
- sprite_idx=15, blank_n_in=0 -> RGB=(0,0,0), VGA_BLANK_N=0.
- FADE_FRAMES=2, fade_out_req, then 8 frame_start pulses -> fade_level=4, fade_busy=1, idx 14 outputs (125,125,125).
- 8 more pulses -> fade_level=0, fade_done pulse, DARK, output (0,0,0).
- fade_in_req and fade_out_req together in DARK -> stays DARK.
- In FADE_OUT at level 5, fade_in_req -> FADE_IN; after 6 frame_start pulses level 8, fade_done, BRIGHT.
- Reset asserted mid-FADE_OUT at level 3 (no clock edge) -> outputs 0, fade_level=8 immediately.
- With SCANLINE_EN defined, idx 14 on DrawY0=1 at level 8 -> (125,125,125); on DrawY0=0 -> (250,250,250).
